spi2i2c_cmd_ctrl: RTL

Command controller directly downstream of the SPI master/slave pair. It consumes bytes from the SPI slave (received data plus data-enable strobe) and parses them into an I2C transaction: a header byte, a length byte, then write data. It buffers the data, drives the request/data handshake of the I2C master engine, and returns status or read data through the SPI slave transmit byte.

---
 rtl/spi2i2c_cmd_ctrl_if.sv | 37 +++
 rtl/spi2i2c_cmd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi2i2c_cmd_ctrl_if.sv
// Bundle of the SPI-slave byte path, the I2C master request/data handshake and
// the controller status lines. The master modport is the command controller's view.
interface spi2i2c_cmd_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] spi_rx_data_i;
    logic             spi_rx_en_i;
    logic [WIDTH-1:0] spi_tx_data_o;
    logic             i2c_req_o;
    logic             i2c_ack_i;
    logic [6:0]       i2c_addr_o;
    logic             i2c_rw_o;
    logic [AW-1:0]    i2c_len_o;
    logic [WIDTH-1:0] i2c_wdata_o;
    logic             i2c_wdata_req_i;
    logic [WIDTH-1:0] i2c_rdata_i;
    logic             i2c_rdata_valid_i;
    logic             i2c_done_i;
    logic             i2c_nack_i;
    logic             busy_o;
    logic             err_o;

    modport master (
        input  spi_rx_data_i, spi_rx_en_i, i2c_ack_i, i2c_wdata_req_i,
               i2c_rdata_i, i2c_rdata_valid_i, i2c_done_i, i2c_nack_i,
        output spi_tx_data_o, i2c_req_o, i2c_addr_o, i2c_rw_o, i2c_len_o,
               i2c_wdata_o, busy_o, err_o
    );

    modport slave (
        output spi_rx_data_i, spi_rx_en_i, i2c_ack_i, i2c_wdata_req_i,
               i2c_rdata_i, i2c_rdata_valid_i, i2c_done_i, i2c_nack_i,
        input  spi_tx_data_o, i2c_req_o, i2c_addr_o, i2c_rw_o, i2c_len_o,
               i2c_wdata_o, busy_o, err_o
    );
endinterface

// File: rtl/spi2i2c_cmd_ctrl.sv
// Parses SPI bytes (header, length, write data) into one I2C transaction, buffers
// the data in a small circular FIFO and returns status or read data to the SPI slave.
module spi2i2c_cmd_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input logic                  clk_i,
    input logic                  reset_i,
    spi2i2c_cmd_ctrl_if.master   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        WDATA,
        REQ,
        XFER,
        DONE,
        RDOUT
    } state_t;

    state_t state_reg, state_next;

    // [0] first sync flop, [1] second sync flop, [2] previous value for edge detect
    logic [2:0] rx_sync_reg;
    logic       rx_pulse;

    logic [6:0]       addr_reg;
    logic             rw_reg;
    logic [AW-1:0]    len_reg;
    logic             len_err_reg;
    logic             nack_reg;
    logic             overrun_reg;
    logic             underflow_reg;

    logic [WIDTH-1:0] mem_reg [0:(1<<PW)-1];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    count_reg;
    logic [WIDTH-1:0] head;

    logic             push;
    logic             pop;
    logic             flush;
    logic [WIDTH-1:0] push_data;
    logic             latch_hdr;
    logic             latch_len;
    logic             set_len_err;
    logic             set_nack;
    logic             set_overrun;
    logic             set_underflow;

    logic             busy;
    logic             err;
    logic [7:0]       status;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_sync_reg <= '0;
        end else begin
            rx_sync_reg <= {rx_sync_reg[1:0], bus.spi_rx_en_i};
        end
    end

    assign rx_pulse = rx_sync_reg[1] & ~rx_sync_reg[2];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        push          = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        push_data     = bus.i2c_rdata_i;
        latch_hdr     = 1'b0;
        latch_len     = 1'b0;
        set_len_err   = 1'b0;
        set_nack      = 1'b0;
        set_overrun   = 1'b0;
        set_underflow = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_pulse) begin
                    latch_hdr  = 1'b1;
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_pulse) begin
                    if (bus.spi_rx_data_i == '0 || bus.spi_rx_data_i > WIDTH'(DEPTH)) begin
                        set_len_err = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        latch_len  = 1'b1;
                        state_next = rw_reg ? REQ : WDATA;
                    end
                end
            end
            WDATA: begin
                if (rx_pulse) begin
                    push      = 1'b1;
                    push_data = bus.spi_rx_data_i;
                    if ((count_reg + AW'(1)) == len_reg) begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.i2c_ack_i) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                if (!rw_reg && bus.i2c_wdata_req_i) begin
                    if (count_reg != '0) begin
                        pop = 1'b1;
                    end else begin
                        set_underflow = 1'b1;
                    end
                end
                if (rw_reg && bus.i2c_rdata_valid_i) begin
                    if (count_reg == AW'(DEPTH)) begin
                        set_overrun = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                if (bus.i2c_done_i) begin
                    set_nack   = bus.i2c_nack_i;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rw_reg && !nack_reg) begin
                    state_next = RDOUT;
                end else begin
                    flush      = 1'b1;
                    state_next = IDLE;
                end
            end
            RDOUT: begin
                if (count_reg == '0) begin
                    state_next = IDLE;
                end else if (rx_pulse) begin
                    pop = 1'b1;
                    if (count_reg == AW'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // SPI bytes arriving while the I2C side owns the buffer cannot be used
        if (rx_pulse && (state_reg == REQ || state_reg == XFER || state_reg == DONE)) begin
            set_overrun = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_reg      <= '0;
            rw_reg        <= 1'b0;
            len_reg       <= '0;
            len_err_reg   <= 1'b0;
            nack_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (latch_hdr) begin
                addr_reg      <= bus.spi_rx_data_i[7:1];
                rw_reg        <= bus.spi_rx_data_i[0];
                len_err_reg   <= 1'b0;
                nack_reg      <= 1'b0;
                overrun_reg   <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (set_len_err)   len_err_reg   <= 1'b1;
                if (set_nack)      nack_reg      <= 1'b1;
                if (set_overrun)   overrun_reg   <= 1'b1;
                if (set_underflow) underflow_reg <= 1'b1;
            end
            if (latch_len) begin
                len_reg <= bus.spi_rx_data_i[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            // Realign the read pointer so the next frame starts with an empty, coherent FIFO
            rd_ptr_reg <= wr_ptr_reg;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                count_reg  <= count_reg + AW'(1);
            end else if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                count_reg  <= count_reg - AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head   = mem_reg[rd_ptr_reg];
    assign busy   = (state_reg != IDLE);
    assign err    = len_err_reg | nack_reg | overrun_reg | underflow_reg;
    assign status = {busy, err, nack_reg, overrun_reg, 4'(count_reg)};

    assign bus.spi_tx_data_o = (state_reg == RDOUT) ? head : status;
    assign bus.i2c_req_o     = (state_reg == REQ);
    assign bus.i2c_addr_o    = addr_reg;
    assign bus.i2c_rw_o      = rw_reg;
    assign bus.i2c_len_o     = len_reg;
    assign bus.i2c_wdata_o   = (!rw_reg && count_reg != '0) ? head : '0;
    assign bus.busy_o        = busy;
    assign bus.err_o         = err;
endmodule
